// File: rtl/tick_scheduler.sv
// Shared tick scheduler: one programmable prescaler produces a base tick, and
// NUM_CH channels count base ticks to emit periodic or one-shot tick pulses.
module tick_scheduler #(
   parameter  int unsigned NUM_CH     = 4,
   parameter  int unsigned PERIOD_W   = 16,
   parameter  int unsigned PRESCALE_W = 32,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic [PRESCALE_W-1:0] i_prescale,
   input  logic                  i_wr_en,
   input  logic [CH_W-1:0]       i_wr_ch,
   input  logic [PERIOD_W-1:0]   i_wr_period,
   input  logic                  i_wr_oneshot,
   input  logic [NUM_CH-1:0]     i_start,
   input  logic [NUM_CH-1:0]     i_stop,
   input  logic [NUM_CH-1:0]     i_ack,
   output logic                  o_base_tick,
   output logic [NUM_CH-1:0]     o_tick,
   output logic [NUM_CH-1:0]     o_busy,
   output logic [NUM_CH-1:0]     o_pending,
   output logic [NUM_CH-1:0]     o_overrun
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic                  be;
   logic                  base_tick_q;

   state_t                state_q [NUM_CH];
   state_t                state_d [NUM_CH];
   logic [PERIOD_W-1:0]   cnt_q [NUM_CH];
   logic [PERIOD_W-1:0]   cnt_d [NUM_CH];
   logic [PERIOD_W-1:0]   period_q [NUM_CH];
   logic [PERIOD_W-1:0]   period_d [NUM_CH];
   logic [NUM_CH-1:0]     oneshot_q, oneshot_d;
   logic [NUM_CH-1:0]     wr_hit;
   logic [NUM_CH-1:0]     fire;
   logic [NUM_CH-1:0]     tick_q;
   logic [NUM_CH-1:0]     pending_q, pending_d;
   logic [NUM_CH-1:0]     overrun_q, overrun_d;

   // Prescaler; >= lets a lowered compare value wrap immediately.
   always_comb begin
      be     = i_enable && (pcnt_q >= i_prescale);
      pcnt_d = '0;
      if (i_enable && !be) begin
         pcnt_d = pcnt_q + PRESCALE_W'(1);
      end
   end

   // Per-channel config, next-state and flag logic.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i]    = i_wr_en && (i_wr_ch == CH_W'(i));
         period_d[i]  = period_q[i];
         oneshot_d[i] = oneshot_q[i];
         if (wr_hit[i]) begin
            period_d[i]  = i_wr_period;
            oneshot_d[i] = i_wr_oneshot;
         end

         fire[i]    = (state_q[i] == RUN) && be && (cnt_q[i] == '0);
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (i_stop[i]) begin
            state_d[i] = IDLE;
         end else if (i_start[i]) begin
            // period_d so a same-cycle write is picked up by the start
            state_d[i] = RUN;
            cnt_d[i]   = period_d[i];
         end else if ((state_q[i] == RUN) && be) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - PERIOD_W'(1);
            end else if (oneshot_q[i]) begin
               state_d[i] = IDLE;
            end else begin
               cnt_d[i] = period_q[i];
            end
         end

         pending_d[i] = pending_q[i];
         overrun_d[i] = overrun_q[i];
         if (fire[i]) begin
            pending_d[i] = 1'b1;
            if (pending_q[i] && !i_ack[i]) begin
               overrun_d[i] = 1'b1;
            end
         end else if (i_ack[i]) begin
            pending_d[i] = 1'b0;
            overrun_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pcnt_q      <= '0;
         base_tick_q <= 1'b0;
         oneshot_q   <= '0;
         tick_q      <= '0;
         pending_q   <= '0;
         overrun_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= IDLE;
            cnt_q[i]    <= '0;
            period_q[i] <= '0;
         end
      end else begin
         pcnt_q      <= pcnt_d;
         base_tick_q <= be;
         oneshot_q   <= oneshot_d;
         tick_q      <= fire;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= state_d[i];
            cnt_q[i]    <= cnt_d[i];
            period_q[i] <= period_d[i];
         end
      end
   end

   always_comb begin
      o_base_tick = base_tick_q;
      o_tick      = tick_q;
      o_pending   = pending_q;
      o_overrun   = overrun_q;
      for (int i = 0; i < NUM_CH; i++) begin
         o_busy[i] = (state_q[i] == RUN);
      end
   end

endmodule
